// File: rtl/data_mem_requester.sv
// Purpose: latches one load/store from the MEM stage, drives the data memory and retires it with Done/Err.
// Latency: load 3 stall cycles + Done, store 4 stall cycles + Done (zero-delay memory, SETTLE_CYCLES=1).
// Backpressure: Stall holds the pipeline from request acceptance until the Done cycle; MemReady paces WAIT.
module data_mem_requester #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned TIMEOUT       = 255,
    parameter logic [31:0] ERR_DATA      = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWriteReq,
    input  logic [31:0] AddrIn,
    input  logic [31:0] WDataIn,
    output logic        Stall,
    output logic [31:0] RData,
    output logic        Done,
    output logic        Err,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData,
    input  logic        MemReady
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        is_wr;
    } req_t;

    localparam logic [7:0] SETTLE_C  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mem_write_q, mem_write_d;

    logic req;
    logic bad_req;

    assign req     = MemRead | MemWriteReq;
    assign bad_req = (AddrIn[1:0] != 2'b00) | (MemRead & MemWriteReq);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        Stall   = 1'b0;
        Done    = 1'b0;
        Err     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    Stall = 1'b1;
                    if (bad_req) begin
                        rdata_d = ERR_DATA;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        req_d.addr  = AddrIn;
                        req_d.wdata = WDataIn;
                        req_d.is_wr = MemWriteReq;
                        cnt_d       = 8'd0;
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                Stall = 1'b1;
                if (cnt_q != TIMEOUT_C) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // MemReady may still reflect the previous address until the settle window passes
                if ((cnt_q >= SETTLE_C) && MemReady) begin
                    if (req_q.is_wr) begin
                        state_d = WRITE;
                    end else begin
                        rdata_d = ReadData;
                        state_d = DONE;
                    end
                end else if (cnt_q == TO_LAST_C) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WRITE: begin
                Stall   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                Done    = 1'b1;
                Err     = err_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobe comes straight from a flop so the memory never sees a decode glitch.
    assign mem_write_d = (state_d == WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= 8'd0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign RData     = rdata_q;
    assign MemWrite  = mem_write_q;
    assign Address   = req_q.addr;
    assign WriteData = req_q.wdata;

    a_write_one_cycle: assert property (@(posedge clk) disable iff (!rst_n) MemWrite |=> !MemWrite);
    a_done_one_cycle:  assert property (@(posedge clk) disable iff (!rst_n) Done |=> !Done);
    a_err_with_done:   assert property (@(posedge clk) disable iff (!rst_n) Err |-> Done);

endmodule

// File: tb/tb_data_mem_requester.sv
// Directed bench for data_mem_requester: word-addressed memory model with programmable MemReady delay,
// plus a second instance with TIMEOUT=8 and MemReady stuck low.
module tb_data_mem_requester;

    localparam logic [31:0] ERR_DATA = 32'hEEEE_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWriteReq;
    logic [31:0] AddrIn, WDataIn;
    logic        Stall, Done, Err, MemWrite, MemReady;
    logic [31:0] RData, Address, WriteData, ReadData;

    logic        t_MemRead, t_MemWriteReq;
    logic [31:0] t_AddrIn, t_WDataIn;
    logic        t_Stall, t_Done, t_Err, t_MemWrite;
    logic [31:0] t_RData, t_Address, t_WriteData;

    logic [31:0] mem [0:255];
    logic        pl_we;
    logic [7:0]  pl_idx;
    logic [31:0] pl_dat;
    int          wait_cnt;
    logic        ready_en;
    int          ready_delay;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_requester #(.SETTLE_CYCLES(1), .TIMEOUT(255), .ERR_DATA(ERR_DATA)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWriteReq(MemWriteReq),
        .AddrIn(AddrIn), .WDataIn(WDataIn), .Stall(Stall), .RData(RData), .Done(Done),
        .Err(Err), .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .MemReady(MemReady)
    );

    data_mem_requester #(.SETTLE_CYCLES(1), .TIMEOUT(8), .ERR_DATA(ERR_DATA)) dut_t (
        .clk(clk), .rst_n(rst_n), .MemRead(t_MemRead), .MemWriteReq(t_MemWriteReq),
        .AddrIn(t_AddrIn), .WDataIn(t_WDataIn), .Stall(t_Stall), .RData(t_RData), .Done(t_Done),
        .Err(t_Err), .MemWrite(t_MemWrite), .Address(t_Address), .WriteData(t_WriteData),
        .ReadData(32'h5555_AAAA), .MemReady(1'b0)
    );

    // Memory model: commits on the edge ending a MemWrite cycle; MemReady rises wait_cnt cycles into a stall.
    always @(posedge clk) begin
        if (MemWrite) mem[Address[9:2]] <= WriteData;
        else if (pl_we) mem[pl_idx] <= pl_dat;
        wait_cnt <= Stall ? wait_cnt + 1 : 0;
    end
    assign ReadData = mem[Address[9:2]];
    assign MemReady = ready_en && (wait_cnt >= ready_delay);

    task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
        @(negedge clk);
        pl_idx = idx;
        pl_dat = dat;
        pl_we  = 1'b1;
        @(posedge clk);
        #1;
        pl_we  = 1'b0;
    endtask

    // Entered at posedge+1; returns at posedge+1 after the retiring edge with the request dropped.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int budget, output int stall_n, output int mw_n, output int done_at,
                           output logic err_o, output logic [31:0] rdata_o);
        stall_n = 0; mw_n = 0; done_at = -1; err_o = 1'b0; rdata_o = 32'h0;
        MemRead = rd; MemWriteReq = wr; AddrIn = addr; WDataIn = wd;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (Stall) stall_n++;
            if (MemWrite) mw_n++;
            if (Done) begin
                done_at = c;
                err_o   = Err;
                rdata_o = RData;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        MemWriteReq = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({Stall, Done, Err, MemWrite} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 0000", {Stall, Done, Err, MemWrite});
        end
        checks++;
        if ({Address, WriteData, RData} !== 96'h0) begin
            errors++; $display("FAIL reset_regs: addr=%h wdata=%h rdata=%h exp all 0", Address, WriteData, RData);
        end
        // Async reset while waiting on a slow memory
        ready_delay = 100;
        MemWriteReq = 1'b1; AddrIn = 32'h44; WDataIn = 32'h1111_2222;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if ({Stall, Address} !== {1'b1, 32'h44}) begin
            errors++; $display("FAIL reset_pre_wait: stall=%b addr=%h exp 1/00000044", Stall, Address);
        end
        #2;
        rst_n = 1'b0; MemWriteReq = 1'b0;
        #1;
        checks++;
        if ({Stall, MemWrite, Done, Err} !== 4'b0000 || Address !== 32'h0) begin
            errors++; $display("FAIL reset_mid_wait: ctrl=%b addr=%h exp 0000/0", {Stall, MemWrite, Done, Err}, Address);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        // Async reset during the write strobe: the commit must not happen
        ready_delay = 0;
        MemWriteReq = 1'b1; AddrIn = 32'h40; WDataIn = 32'h9999_8888;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++; $display("FAIL reset_pre_write: MemWrite=%b exp 1", MemWrite);
        end
        #2;
        rst_n = 1'b0; MemWriteReq = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || Address !== 32'h0) begin
            errors++; $display("FAIL reset_mid_write: MemWrite=%b addr=%h exp 0/0", MemWrite, Address);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem[16] !== 32'h0) begin
            errors++; $display("FAIL reset_no_commit: mem[0x40]=%h exp 0", mem[16]);
        end
    endtask

    task automatic test_load;
        int s, w, d; logic e; logic [31:0] r;
        ready_delay = 0;
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 20, s, w, d, e, r);
        checks++;
        if (s !== 3 || d !== 3) begin
            errors++; $display("FAIL load_latency: stall=%0d done_at=%0d exp 3/3", s, d);
        end
        checks++;
        if (e !== 1'b0 || r !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL load_data: err=%b rdata=%h exp 0/cafef00d", e, r);
        end
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL load_no_write: writes=%0d exp 0", w);
        end
    endtask

    task automatic test_store;
        int s, w, d; logic e; logic [31:0] r;
        ready_delay = 0;
        run_req(1'b0, 1'b1, 32'h24, 32'h1234_5678, 20, s, w, d, e, r);
        checks++;
        if (w !== 1) begin
            errors++; $display("FAIL store_strobe: writes=%0d exp 1", w);
        end
        checks++;
        if (s !== 4 || d !== 4 || e !== 1'b0) begin
            errors++; $display("FAIL store_latency: stall=%0d done_at=%0d err=%b exp 4/4/0", s, d, e);
        end
        checks++;
        if (Address !== 32'h24 || mem[9] !== 32'h1234_5678) begin
            errors++; $display("FAIL store_commit: addr=%h mem=%h exp 00000024/12345678", Address, mem[9]);
        end
        run_req(1'b1, 1'b0, 32'h24, 32'h0, 20, s, w, d, e, r);
        checks++;
        if (r !== 32'h1234_5678 || e !== 1'b0) begin
            errors++; $display("FAIL store_readback: rdata=%h err=%b exp 12345678/0", r, e);
        end
    endtask

    task automatic test_back_to_back;
        int s, w, d; logic e; logic [31:0] r;
        ready_delay = 0;
        run_req(0, 1, 32'h30, 32'hA5A5_0F0F, 20, s, w, d, e, r);
        run_req(1, 0, 32'h30, 32'h0, 20, s, w, d, e, r);
        checks++;
        if (d !== 3 || r !== 32'hA5A5_0F0F) begin
            errors++; $display("FAIL b2b_load: done_at=%0d rdata=%h exp 3/a5a50f0f", d, r);
        end
        run_req(1, 0, 32'h10, 32'h0, 20, s, w, d, e, r);
        checks++;
        if (d !== 3 || r !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL b2b_load2: done_at=%0d rdata=%h exp 3/cafef00d", d, r);
        end
    endtask

    task automatic test_slow;
        int s, w, d; logic e; logic [31:0] r;
        ready_delay = 21;
        run_req(1, 0, 32'h10, 32'h0, 60, s, w, d, e, r);
        checks++;
        if (s !== 22 || d !== 22) begin
            errors++; $display("FAIL slow_latency: stall=%0d done_at=%0d exp 22/22", s, d);
        end
        checks++;
        if (e !== 1'b0 || r !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL slow_data: err=%b rdata=%h exp 0/cafef00d", e, r);
        end
        ready_delay = 0;
    endtask

    task automatic test_errors;
        int s, w, d; logic e; logic [31:0] r;
        run_req(1, 0, 32'h13, 32'h0, 20, s, w, d, e, r);
        checks++;
        if (s !== 1 || d !== 1 || e !== 1'b1) begin
            errors++; $display("FAIL err_misalign: stall=%0d done_at=%0d err=%b exp 1/1/1", s, d, e);
        end
        checks++;
        if (r !== ERR_DATA || Address !== 32'h10 || w !== 0) begin
            errors++; $display("FAIL err_misalign_side: rdata=%h addr=%h writes=%0d exp %h/00000010/0", r, Address, w, ERR_DATA);
        end
        run_req(1, 1, 32'h20, 32'h0000_ABCD, 20, s, w, d, e, r);
        checks++;
        if (s !== 1 || d !== 1 || e !== 1'b1 || r !== ERR_DATA) begin
            errors++; $display("FAIL err_both: stall=%0d done_at=%0d err=%b rdata=%h exp 1/1/1/%h", s, d, e, r, ERR_DATA);
        end
        checks++;
        if (Address !== 32'h10 || WriteData !== 32'h0 || w !== 0) begin
            errors++; $display("FAIL err_both_side: addr=%h wdata=%h writes=%0d exp 00000010/0/0", Address, WriteData, w);
        end
        checks++;
        if ({Done, Err} !== 2'b00) begin
            errors++; $display("FAIL err_pulse: done/err=%b exp 00 after retire", {Done, Err});
        end
        run_req(1, 0, 32'h10, 32'h0, 20, s, w, d, e, r);
        checks++;
        if (e !== 1'b0 || r !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL err_clear: err=%b rdata=%h exp 0/cafef00d", e, r);
        end
    endtask

    task automatic test_timeout;
        int s = 0, w = 0, d = -1;
        logic e = 1'b0;
        logic [31:0] r = 32'h0;
        t_MemWriteReq = 1'b1; t_AddrIn = 32'h50; t_WDataIn = 32'h77;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (t_Stall) s++;
            if (t_MemWrite) w++;
            if (t_Done) begin
                d = c; e = t_Err; r = t_RData;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        t_MemWriteReq = 1'b0;
        checks++;
        if (d !== 9 || e !== 1'b1) begin
            errors++; $display("FAIL timeout_done: done_at=%0d err=%b exp 9/1", d, e);
        end
        checks++;
        if (r !== ERR_DATA || w !== 0 || s !== 9) begin
            errors++; $display("FAIL timeout_side: rdata=%h writes=%0d stall=%0d exp %h/0/9", r, w, s, ERR_DATA);
        end
        checks++;
        if (t_Address !== 32'h50 || t_WriteData !== 32'h77) begin
            errors++; $display("FAIL timeout_regs: addr=%h wdata=%h exp 00000050/00000077", t_Address, t_WriteData);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        MemRead = 1'b0; MemWriteReq = 1'b0; AddrIn = 32'h0; WDataIn = 32'h0;
        t_MemRead = 1'b0; t_MemWriteReq = 1'b0; t_AddrIn = 32'h0; t_WDataIn = 32'h0;
        pl_we = 1'b0; pl_idx = 8'h0; pl_dat = 32'h0;
        ready_en = 1'b1; ready_delay = 0;
        preload(8'd4, 32'hCAFE_F00D);
        preload(8'd16, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_slow();
        test_errors();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
        $fatal(1);
    end

endmodule
